// File: rtl/demorgan_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : demorgan_sweep_checker
// Description : Clocked, deterministic exhaustive checker for a WIDTH-input
//               De Morgan gate. Steps vec_out through 0 .. 2^WIDTH-1, holds
//               each vector for HOLD settle cycles, samples dut_y once, and
//               compares it with the NAND (MODE=0) or NOR (MODE=1) identity.
//               Mismatches are counted and the first failing vector is kept.
// Ports       : clk             rising-edge clock
//               rst_n           asynchronous active-low reset
//               start           begin a sweep (honoured in IDLE or DONE)
//               dut_y           DUT output, combinational from vec_out
//               vec_out         stimulus vector to the DUT
//               busy            sweep in progress (SETTLE or SAMPLE)
//               done            sweep finished, held until next start
//               pass            done with zero mismatches
//               err_count       number of mismatching vectors
//               first_err_vec   vector of the first mismatch
//               first_err_valid first_err_vec holds a captured value
// Revision    : 1.0 - initial release
// ============================================================================
module demorgan_sweep_checker #(
    parameter int WIDTH = 2,
    parameter int MODE  = 0,
    parameter int HOLD  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dut_y,
    output logic [WIDTH-1:0] vec_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH:0]   err_count,
    output logic [WIDTH-1:0] first_err_vec,
    output logic             first_err_valid
);

    // Settle counter only needs to reach HOLD-1.
    localparam int                 c_CNT_W     = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(HOLD - 1);
    localparam logic [WIDTH-1:0]   c_ALL_ONES  = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_vec;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [WIDTH:0]     r_err;
    logic [WIDTH-1:0]   r_first_vec;
    logic               r_first_valid;

    logic               w_expected;
    logic               w_mismatch;
    logic [WIDTH:0]     w_err_next;

    assign w_expected = (MODE == 0) ? ~(&r_vec) : ~(|r_vec);
    assign w_mismatch = (dut_y != w_expected);
    // Count including the current sample, so pass reflects the final vector.
    assign w_err_next = r_err + {{WIDTH{1'b0}}, w_mismatch};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_vec         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_err         <= '0;
            r_first_vec   <= '0;
            r_first_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state       <= S_SETTLE;
                        r_cnt         <= '0;
                        r_vec         <= '0;
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                        r_pass        <= 1'b0;
                        r_err         <= '0;
                        r_first_vec   <= '0;
                        r_first_valid <= 1'b0;
                    end
                end

                S_SETTLE: begin
                    if (r_cnt == c_HOLD_LAST) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_SAMPLE: begin
                    if (w_mismatch) begin
                        r_err <= w_err_next;
                        if (!r_first_valid) begin
                            r_first_vec   <= r_vec;
                            r_first_valid <= 1'b1;
                        end
                    end
                    if (r_vec == c_ALL_ONES) begin
                        // Last vector: vec_out stays at all-ones in DONE.
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == '0);
                    end else begin
                        r_state <= S_SETTLE;
                        r_vec   <= r_vec + 1'b1;
                        r_cnt   <= '0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign vec_out         = r_vec;
    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign err_count       = r_err;
    assign first_err_vec   = r_first_vec;
    assign first_err_valid = r_first_valid;

endmodule
`default_nettype wire
